ysyx_22040386_pipe_ctrl: RTL and testbench
==========================================

# ysyx_22040386_pipe_ctrl

Pipeline scheduler for the 5-stage core. It sits beside the decode stage, tracks the destinations of in-flight instructions in a 3-slot scoreboard (EX, MEM, WB), and produces forwarding selects for the decoded instruction. It also drives the per-stage enable/flush/bubble controls for load-use stalls, EX-resolved redirects and memory-busy freezes, and drains the pipe into a halt on ebreak.

## Interface
Parameters:
- CNT_W, 32, width of the stall-cycle performance counter

Ports:
- i_clk  in  1  core clock
- i_rst  in  1  reset, asynchronous, active-high
- i_ID_valid  in  1  ID holds a real instruction
- i_ID_rs1_addr / i_ID_rs2_addr  in  5 each  source register addresses
- i_ID_rs1_used / i_ID_rs2_used  in  1 each  source actually read by the instruction
- i_ID_RegWrite  in  1  decoded instruction writes rd
- i_ID_MemRead  in  1  decoded instruction is a load
- i_ID_reg_wr_addr  in  5  decoded rd
- i_ID_ebreak  in  1  decoded instruction is ebreak (32'h0010_0073)
- i_EX_redirect  in  1  branch taken / jal / jalr resolved in EX this cycle
- i_MEM_busy  in  1  data memory not ready; whole pipe must freeze
- o_IF_pc_en, o_IFID_en, o_IDEX_en, o_EXMEM_en, o_MEMWB_en  out  1 each  register update enables
- o_IFID_flush  out  1  IF/ID loads a NOP
- o_IDEX_bubble  out  1  ID/EX loads a NOP
- o_fwd_a / o_fwd_b  out  2 each  operand source: 00 regfile, 01 EX slot, 10 MEM slot, 11 WB slot
- o_halt  out  1  pipe drained after ebreak
- o_stall_cnt  out  CNT_W  cycles with any stall, bubble or freeze

## Operation
- Scoreboard slot contents: {valid, rd, RegWrite, MemRead}. When not frozen, each cycle shifts EX→MEM→WB. EX loads the ID instruction, or an invalid entry when a bubble is inserted.
- Matching: a slot matches a source if the slot is valid, RegWrite=1, rd==src, src!=0, and the source is used. Youngest match wins (EX > MEM > WB). No match → 00.
- Load-use: EX slot matches a used source with MemRead=1, and i_ID_valid=1. Effect: o_IF_pc_en=0, o_IFID_en=0, o_IDEX_bubble=1. ID is re-evaluated next cycle, when the load sits in MEM → select 10.
- Redirect: i_EX_redirect=1 → o_IFID_flush=1, o_IDEX_bubble=1, PC enabled. Redirect has priority over load-use; the flushed ID instruction is not tracked.
- Freeze: i_MEM_busy=1 → all enables 0, flush/bubble 0, and scoreboard, state and redirect actions held. Freeze has priority over everything except reset.
- FSM states:
  - RUN: normal operation. On ebreak in ID (i_ID_valid=1, not flushed, not frozen, no load-use) → DRAIN, drain counter=0. The ebreak itself enters EX.
  - DRAIN: o_IF_pc_en=0, o_IFID_flush=1. Counter increments on unfrozen cycles. At count 3 (ebreak has left WB) → HALT. A redirect in DRAIN is ignored (older instructions only).
  - HALT: all enables 0, o_halt=1. Exit only by reset.
- o_stall_cnt: +1 on any unfrozen-or-frozen cycle where a load-use stall, bubble, flush or freeze is active, in RUN or DRAIN. Saturates at all-ones.

## Timing
- Forward selects, enables, flush and bubble are combinational from inputs, scoreboard and state. They are valid in the same cycle.
- Scoreboard, FSM, drain counter and o_stall_cnt update on the rising edge of i_clk.
- Load-use costs exactly 1 bubble cycle (2 if a freeze overlaps; frozen cycles add 1:1).
- Redirect costs 2 squashed instructions (IF/ID and ID/EX).
- Ebreak to o_halt=1: 4 unfrozen cycles after ebreak is accepted in ID.
- Reset while asserted:
  - State=RUN, scoreboard invalid, counter=0, o_stall_cnt=0, o_halt=0.
  - All enables=0, o_IFID_flush=1, o_IDEX_bubble=1, fwd selects=00.
- Reset mid-DRAIN or in HALT returns to RUN with all of the above values.
- x0 is never a hazard source.

## Test plan
- Back-to-back dependent ALU ops: add x5 then sub using rs1=x5 → o_fwd_a=01. One intervening NOP → 10. Two NOPs → 11. Three → 00. No stalls.
- Load-use: lw x6 then add rs2=x6 → one cycle with o_IFID_en=0, o_IDEX_bubble=1; next cycle o_fwd_b=10. o_stall_cnt +1.
- Redirect coincident with load-use: i_EX_redirect=1 → o_IFID_flush=1, o_IDEX_bubble=1, o_IF_pc_en=1. The squashed consumer is never forwarded.
- i_MEM_busy for 3 cycles during a load-use stall → all enables 0 for 3 cycles, scoreboard unchanged. Bubble issues after release. o_stall_cnt +4.
- ebreak decoded → o_IF_pc_en=0 from the next cycle; o_halt=1 after 4 cycles; one freeze cycle mid-drain delays o_halt by 1. Reset afterwards clears o_halt and returns to RUN.
- Source x0 with an EX slot rd=x0 RegWrite=1 → o_fwd_a=00, no stall.

Source files
------------

// File: rtl/ysyx_22040386_pipe_ctrl_if.sv
// Bundle between the decode-side pipeline and the scheduler: decoded
// instruction fields and stage events in, stage controls and forwarding out.
interface ysyx_22040386_pipe_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    // Decoded instruction currently in ID
    logic             i_ID_valid;
    logic [4:0]       i_ID_rs1_addr;
    logic [4:0]       i_ID_rs2_addr;
    logic             i_ID_rs1_used;
    logic             i_ID_rs2_used;
    logic             i_ID_RegWrite;
    logic             i_ID_MemRead;
    logic [4:0]       i_ID_reg_wr_addr;
    logic             i_ID_ebreak;

    // Events from later stages
    logic             i_EX_redirect;
    logic             i_MEM_busy;

    // Stage register controls
    logic             o_IF_pc_en;
    logic             o_IFID_en;
    logic             o_IDEX_en;
    logic             o_EXMEM_en;
    logic             o_MEMWB_en;
    logic             o_IFID_flush;
    logic             o_IDEX_bubble;

    // Operand forwarding and status
    logic [1:0]       o_fwd_a;
    logic [1:0]       o_fwd_b;
    logic             o_halt;
    logic [CNT_W-1:0] o_stall_cnt;

    // Core side: drives the decoded instruction and events
    modport master (
        output i_ID_valid, i_ID_rs1_addr, i_ID_rs2_addr, i_ID_rs1_used, i_ID_rs2_used,
        output i_ID_RegWrite, i_ID_MemRead, i_ID_reg_wr_addr, i_ID_ebreak,
        output i_EX_redirect, i_MEM_busy,
        input  o_IF_pc_en, o_IFID_en, o_IDEX_en, o_EXMEM_en, o_MEMWB_en,
        input  o_IFID_flush, o_IDEX_bubble, o_fwd_a, o_fwd_b, o_halt, o_stall_cnt
    );

    // Scheduler side
    modport slave (
        input  i_ID_valid, i_ID_rs1_addr, i_ID_rs2_addr, i_ID_rs1_used, i_ID_rs2_used,
        input  i_ID_RegWrite, i_ID_MemRead, i_ID_reg_wr_addr, i_ID_ebreak,
        input  i_EX_redirect, i_MEM_busy,
        output o_IF_pc_en, o_IFID_en, o_IDEX_en, o_EXMEM_en, o_MEMWB_en,
        output o_IFID_flush, o_IDEX_bubble, o_fwd_a, o_fwd_b, o_halt, o_stall_cnt
    );
endinterface

// File: rtl/ysyx_22040386_pipe_ctrl.sv
// Pipeline scheduler: 3-slot destination scoreboard (EX/MEM/WB) producing
// forwarding selects, plus stage enable/flush/bubble control for load-use
// stalls, EX redirects, memory freezes and the ebreak drain-to-halt sequence.
module ysyx_22040386_pipe_ctrl #(
    parameter int unsigned CNT_W = 32
) (
    input logic                            i_clk,
    input logic                            i_rst,
    ysyx_22040386_pipe_ctrl_if.slave       bus
);

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       reg_write;
        logic       mem_read;
    } slot_t;

    typedef enum logic [1:0] {
        StRun,
        StDrain,
        StHalt
    } state_e;

    // A slot supplies a source when it really writes that (non-x0) register
    function automatic logic slot_hit(slot_t s, logic [4:0] src, logic used);
        return s.valid && s.reg_write && (s.rd == src) && (src != 5'd0) && used;
    endfunction

    // Youngest producer wins
    function automatic logic [1:0] fwd_sel(slot_t ex, slot_t mem, slot_t wb,
                                           logic [4:0] src, logic used);
        if (slot_hit(ex, src, used)) begin
            return 2'b01;
        end else if (slot_hit(mem, src, used)) begin
            return 2'b10;
        end else if (slot_hit(wb, src, used)) begin
            return 2'b11;
        end
        return 2'b00;
    endfunction

    slot_t            ex_q, mem_q, wb_q;
    slot_t            ex_d, mem_d, wb_d;
    state_e           state_q, state_d;
    logic [1:0]       drain_q, drain_d;
    logic [CNT_W-1:0] stall_q, stall_d;

    logic             frozen;
    logic             advance;
    logic             load_use;
    logic             pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic             ifid_flush, idex_bubble;
    logic             stall_evt;

    assign frozen  = bus.i_MEM_busy;
    // Scoreboard, drain counter and FSM only move on unfrozen, non-halted cycles
    assign advance = !frozen && (state_q != StHalt);

    // Load-use: the load sits in EX and the ID instruction reads its rd
    always_comb begin
        load_use = 1'b0;
        if (state_q == StRun && bus.i_ID_valid && ex_q.mem_read) begin
            load_use = slot_hit(ex_q, bus.i_ID_rs1_addr, bus.i_ID_rs1_used) ||
                       slot_hit(ex_q, bus.i_ID_rs2_addr, bus.i_ID_rs2_used);
        end
    end

    // Stage controls, priority: reset > halt/freeze > drain > redirect > load-use
    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        if (i_rst) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            memwb_en    = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (state_q == StHalt || frozen) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
        end else if (state_q == StDrain) begin
            // Only older instructions may finish; anything behind ebreak is squashed
            pc_en       = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (bus.i_EX_redirect) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (load_use) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_bubble = 1'b1;
        end
    end

    // Forwarding selects for both operands
    always_comb begin
        bus.o_fwd_a = 2'b00;
        bus.o_fwd_b = 2'b00;
        if (!i_rst) begin
            bus.o_fwd_a = fwd_sel(ex_q, mem_q, wb_q, bus.i_ID_rs1_addr, bus.i_ID_rs1_used);
            bus.o_fwd_b = fwd_sel(ex_q, mem_q, wb_q, bus.i_ID_rs2_addr, bus.i_ID_rs2_used);
        end
    end

    assign bus.o_IF_pc_en    = pc_en;
    assign bus.o_IFID_en     = ifid_en;
    assign bus.o_IDEX_en     = idex_en;
    assign bus.o_EXMEM_en    = exmem_en;
    assign bus.o_MEMWB_en    = memwb_en;
    assign bus.o_IFID_flush  = ifid_flush;
    assign bus.o_IDEX_bubble = idex_bubble;
    assign bus.o_halt        = (state_q == StHalt);
    assign bus.o_stall_cnt   = stall_q;

    // Scoreboard shift: ID enters EX unless squashed into a bubble
    always_comb begin
        ex_d  = ex_q;
        mem_d = mem_q;
        wb_d  = wb_q;
        if (advance) begin
            wb_d  = mem_q;
            mem_d = ex_q;
            ex_d  = '0;
            if (bus.i_ID_valid && !idex_bubble) begin
                ex_d.valid     = 1'b1;
                ex_d.rd        = bus.i_ID_reg_wr_addr;
                ex_d.reg_write = bus.i_ID_RegWrite;
                ex_d.mem_read  = bus.i_ID_MemRead;
            end
        end
    end

    // FSM next state and drain counter
    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        if (advance) begin
            unique case (state_q)
                StRun: begin
                    // The ebreak is accepted only when it really moves into EX
                    if (bus.i_ID_valid && bus.i_ID_ebreak && !idex_bubble) begin
                        state_d = StDrain;
                        drain_d = 2'd0;
                    end
                end
                StDrain: begin
                    drain_d = drain_q + 2'd1;
                    // Third unfrozen drain step retires ebreak out of WB
                    if (drain_q == 2'd2) begin
                        state_d = StHalt;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    // Saturating count of cycles lost to stall, bubble, flush or freeze
    always_comb begin
        stall_evt = (state_q != StHalt) && (frozen || ifid_flush || idex_bubble);
        stall_d   = stall_q;
        if (stall_evt && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // State registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ex_q    <= '0;
            mem_q   <= '0;
            wb_q    <= '0;
            state_q <= StRun;
            drain_q <= 2'd0;
            stall_q <= '0;
        end else begin
            ex_q    <= ex_d;
            mem_q   <= mem_d;
            wb_q    <= wb_d;
            state_q <= state_d;
            drain_q <= drain_d;
            stall_q <= stall_d;
        end
    end

endmodule

// File: tb/tb_ysyx_22040386_pipe_ctrl.sv
// Bench for the pipeline scheduler: directed hazard scenarios followed by a
// random instruction stream, all checked against an in-bench pipeline model.
module tb_ysyx_22040386_pipe_ctrl;

    localparam int unsigned CW  = 6;
    localparam int unsigned MAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ysyx_22040386_pipe_ctrl_if #(.CNT_W(CW)) bus ();

    ysyx_22040386_pipe_ctrl #(.CNT_W(CW)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    // Model: list of in-flight instructions, index 0 = youngest (EX)
    typedef struct {
        logic       v;
        logic [4:0] rd;
        logic       rw;
        logic       mr;
    } ent_t;

    ent_t        pipe [3];
    int          m_state;  // 0 running, 1 draining, 2 halted
    int          m_dcnt;
    int unsigned m_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    logic x_eb = 1'b0, x_red = 1'b0, x_busy = 1'b0, x_rst = 1'b1;
    logic [4:0] e_en;
    logic       e_flush, e_bubble;
    logic [1:0] e_fa, e_fb;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int a = 0; a < 3; a++) pipe[a] = '{v: 1'b0, rd: 5'd0, rw: 1'b0, mr: 1'b0};
        m_state = 0;
        m_dcnt  = 0;
        m_cnt   = 0;
    endtask

    // Age (1..3) of the youngest in-flight writer of src, 0 if none
    function automatic logic [1:0] m_fwd(logic [4:0] src, logic used);
        for (int a = 0; a < 3; a++) begin
            if (pipe[a].v && pipe[a].rw && pipe[a].rd == src && src != 5'd0 && used)
                return 2'(a + 1);
        end
        return 2'd0;
    endfunction

    task automatic model_expect();
        logic lu;
        e_fa = m_fwd(bus.i_ID_rs1_addr, bus.i_ID_rs1_used);
        e_fb = m_fwd(bus.i_ID_rs2_addr, bus.i_ID_rs2_used);
        lu = (m_state == 0) && bus.i_ID_valid && pipe[0].mr &&
             (e_fa == 2'd1 || e_fb == 2'd1);
        e_flush  = 1'b0;
        e_bubble = 1'b0;
        e_en     = 5'b11111;
        if (x_rst) begin
            e_en = 5'b00000; e_flush = 1'b1; e_bubble = 1'b1; e_fa = 2'd0; e_fb = 2'd0;
        end else if (m_state == 2 || x_busy) begin
            e_en = 5'b00000;
        end else if (m_state == 1) begin
            e_en = 5'b01111; e_flush = 1'b1; e_bubble = 1'b1;
        end else if (x_red) begin
            e_flush = 1'b1; e_bubble = 1'b1;
        end else if (lu) begin
            e_en = 5'b00111; e_bubble = 1'b1;
        end
    endtask

    task automatic model_advance();
        if (m_state != 2 && (x_busy || e_flush || e_bubble) && m_cnt != MAX) m_cnt++;
        if (m_state == 2 || x_busy) return;
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        pipe[0].v  = bus.i_ID_valid && !e_bubble;
        pipe[0].rd = bus.i_ID_reg_wr_addr;
        pipe[0].rw = bus.i_ID_RegWrite;
        pipe[0].mr = bus.i_ID_MemRead;
        if (m_state == 0 && bus.i_ID_valid && x_eb && !e_bubble) begin
            m_state = 1;
            m_dcnt  = 0;
        end else if (m_state == 1) begin
            m_dcnt++;
            if (m_dcnt == 3) m_state = 2;
        end
    endtask

    // Apply one cycle of inputs and check every output against the model
    task automatic drive(input logic v, input logic [4:0] rd, rs1, rs2,
                         input logic u1, u2, rw, mr);
        bus.i_ID_valid       = v;
        bus.i_ID_reg_wr_addr = rd;
        bus.i_ID_rs1_addr    = rs1;
        bus.i_ID_rs2_addr    = rs2;
        bus.i_ID_rs1_used    = u1;
        bus.i_ID_rs2_used    = u2;
        bus.i_ID_RegWrite    = rw;
        bus.i_ID_MemRead     = mr;
        bus.i_ID_ebreak      = x_eb;
        bus.i_EX_redirect    = x_red;
        bus.i_MEM_busy       = x_busy;
        rst                  = x_rst;
        #1;
        if (x_rst) model_reset();
        model_expect();
        chk("pc_en",    32'(bus.o_IF_pc_en),    32'(e_en[4]));
        chk("ifid_en",  32'(bus.o_IFID_en),     32'(e_en[3]));
        chk("idex_en",  32'(bus.o_IDEX_en),     32'(e_en[2]));
        chk("exmem_en", 32'(bus.o_EXMEM_en),    32'(e_en[1]));
        chk("memwb_en", 32'(bus.o_MEMWB_en),    32'(e_en[0]));
        chk("flush",    32'(bus.o_IFID_flush),  32'(e_flush));
        chk("bubble",   32'(bus.o_IDEX_bubble), 32'(e_bubble));
        chk("fwd_a",    32'(bus.o_fwd_a),       32'(e_fa));
        chk("fwd_b",    32'(bus.o_fwd_b),       32'(e_fb));
        chk("halt",     32'(bus.o_halt),        32'(m_state == 2));
        chk("stall_cnt", 32'(bus.o_stall_cnt),  m_cnt);
    endtask

    task automatic tick();
        @(posedge clk);
        if (!x_rst) model_advance();
        #1;
    endtask

    task automatic nop();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
    endtask

    initial begin
        model_reset();

        // Reset values
        x_rst = 1'b1;
        drive(1'b1, 5'd3, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("rst_pc_en", 32'(bus.o_IF_pc_en), 32'd0);
        chk("rst_flush", 32'(bus.o_IFID_flush), 32'd1);
        chk("rst_bubble", 32'(bus.o_IDEX_bubble), 32'd1);
        chk("rst_cnt", 32'(bus.o_stall_cnt), 32'd0);
        tick();
        x_rst = 1'b0;

        // Forwarding distance: 0..3 NOPs between producer and consumer
        for (int gap = 0; gap < 4; gap++) begin
            drive(1'b1, 5'd5, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0);
            tick();
            repeat (gap) nop();
            drive(1'b1, 5'd9, 5'd5, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0);
            chk("dist_fwd_a", 32'(bus.o_fwd_a), (gap == 3) ? 32'd0 : 32'(gap + 1));
            chk("dist_no_stall", 32'(bus.o_IDEX_bubble), 32'd0);
            tick();
        end

        // Load-use: one bubble, then forward from MEM
        drive(1'b1, 5'd6, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1);
        tick();
        drive(1'b1, 5'd7, 5'd2, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("lu_ifid_en", 32'(bus.o_IFID_en), 32'd0);
        chk("lu_bubble", 32'(bus.o_IDEX_bubble), 32'd1);
        tick();
        drive(1'b1, 5'd7, 5'd2, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("lu_fwd_b", 32'(bus.o_fwd_b), 32'd2);
        chk("lu_resume", 32'(bus.o_IFID_en), 32'd1);
        tick();

        // Redirect on top of load-use: consumer squashed, never forwarded
        drive(1'b1, 5'd7, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1);
        tick();
        x_red = 1'b1;
        drive(1'b1, 5'd8, 5'd7, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("red_flush", 32'(bus.o_IFID_flush), 32'd1);
        chk("red_pc_en", 32'(bus.o_IF_pc_en), 32'd1);
        tick();
        x_red = 1'b0;
        nop();
        drive(1'b1, 5'd10, 5'd8, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("red_sq_fwd_a", 32'(bus.o_fwd_a), 32'd0);
        chk("red_ld_fwd_b", 32'(bus.o_fwd_b), 32'd3);
        tick();

        // Freeze during a load-use stall
        drive(1'b1, 5'd8, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1);
        tick();
        x_busy = 1'b1;
        repeat (3) begin
            drive(1'b1, 5'd9, 5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
            chk("frz_memwb_en", 32'(bus.o_MEMWB_en), 32'd0);
            chk("frz_bubble", 32'(bus.o_IDEX_bubble), 32'd0);
            tick();
        end
        x_busy = 1'b0;
        drive(1'b1, 5'd9, 5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("frz_then_bubble", 32'(bus.o_IDEX_bubble), 32'd1);
        tick();
        drive(1'b1, 5'd9, 5'd8, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("frz_fwd_a", 32'(bus.o_fwd_a), 32'd2);
        tick();

        // x0 is never a hazard
        drive(1'b1, 5'd0, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        drive(1'b1, 5'd11, 5'd0, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("x0_fwd_a", 32'(bus.o_fwd_a), 32'd0);
        chk("x0_no_stall", 32'(bus.o_IDEX_bubble), 32'd0);
        tick();

        // Ebreak drain to halt
        x_eb = 1'b1;
        drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        x_eb = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            drive(1'b1, 5'd12, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0);
            chk("eb_halt", 32'(bus.o_halt), (k == 4) ? 32'd1 : 32'd0);
            chk("eb_pc_en", 32'(bus.o_IF_pc_en), 32'd0);
            tick();
        end
        x_rst = 1'b1;
        nop();
        x_rst = 1'b0;
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("post_rst_halt", 32'(bus.o_halt), 32'd0);
        chk("post_rst_pc_en", 32'(bus.o_IF_pc_en), 32'd1);
        tick();

        // Ebreak drain with one frozen cycle: halt one cycle later
        x_eb = 1'b1;
        drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        x_eb = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            x_busy = (k == 2);
            drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
            chk("ebf_halt", 32'(bus.o_halt), (k == 5) ? 32'd1 : 32'd0);
            tick();
        end
        x_busy = 1'b0;
        x_rst  = 1'b1;
        nop();
        x_rst  = 1'b0;

        // Random instruction stream
        for (int n = 0; n < 3000; n++) begin
            x_rst  = ($urandom % 200 == 0) || (m_state == 2 && $urandom % 10 == 0);
            x_eb   = ($urandom % 60 == 0);
            x_red  = ($urandom % 8 == 0);
            x_busy = ($urandom % 6 == 0);
            drive(($urandom % 8) != 0, 5'($urandom % 8), 5'($urandom % 8), 5'($urandom % 8),
                  1'($urandom), 1'($urandom), ($urandom % 4) != 0, ($urandom % 3) == 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
